// File: rtl/rv32i_types.sv
// Shared RV32I types: word/register/mask aliases, load/store funct3
// encodings and the load/store unit state enumeration.
package rv32i_types;

   typedef logic [31:0] rv32i_word;
   typedef logic [4:0]  rv32i_reg;
   typedef logic [3:0]  rv32i_mem_wmask;

   typedef enum logic [2:0] {
      lb  = 3'b000,
      lh  = 3'b001,
      lw  = 3'b010,
      lbu = 3'b100,
      lhu = 3'b101
   } load_funct3_t;

   typedef enum logic [2:0] {
      sb = 3'b000,
      sh = 3'b001,
      sw = 3'b010
   } store_funct3_t;

   typedef enum logic [1:0] {
      IDLE,
      MEM,
      RESP
   } lsu_state_t;

   // Offset bits that must be zero for a halfword / word access
   localparam logic [1:0] HALF_ALIGN_MASK = 2'b01;
   localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational lane logic for the load/store unit: alignment and funct3
// fault detection, store byte-enable and lane replication, load extraction.
module lsu_align
   import rv32i_types::*;
#(
   parameter bit NONE_FUNCT3_CHECK = 1'b1
)
(
   input  logic           isStore_i,
   input  logic [2:0]     funct3_i,
   input  logic [1:0]     offset_i,
   input  rv32i_word      storeData_i,
   input  rv32i_word      loadWord_i,
   output rv32i_mem_wmask wmask_o,
   output rv32i_word      wdata_o,
   output rv32i_word      rdata_o,
   output logic           fault_o
);

   logic       illegal;
   logic       misaligned;
   logic [2:0] effFunct3;
   logic [7:0] byteSel;
   logic [15:0] halfSel;

   // Classify funct3; unknown encodings either fault or fall back to a word access
   always_comb begin
      illegal   = 1'b0;
      effFunct3 = funct3_i;
      if (isStore_i) begin
         if (funct3_i > 3'b010) begin
            illegal = 1'b1;
         end
      end else begin
         if ((funct3_i == 3'b011) || (funct3_i[2:1] == 2'b11)) begin
            illegal = 1'b1;
         end
      end
      if (illegal && !NONE_FUNCT3_CHECK) begin
         effFunct3 = 3'b010;
      end
   end

   // Alignment check based on the access size held in the low funct3 bits
   always_comb begin
      misaligned = 1'b0;
      case (effFunct3[1:0])
         2'b01:   misaligned = ((offset_i & HALF_ALIGN_MASK) != 2'b00);
         2'b10:   misaligned = ((offset_i & WORD_ALIGN_MASK) != 2'b00);
         default: misaligned = 1'b0;
      endcase
      fault_o = (illegal && NONE_FUNCT3_CHECK) || misaligned;
   end

   // Store byte enables and lane-replicated data; loads never enable bytes
   always_comb begin
      wmask_o = 4'b0000;
      wdata_o = storeData_i;
      if (isStore_i) begin
         case (effFunct3)
            sb: begin
               wmask_o = 4'b0001 << offset_i;
               wdata_o = {4{storeData_i[7:0]}};
            end
            sh: begin
               wmask_o = 4'b0011 << offset_i;
               wdata_o = {2{storeData_i[15:0]}};
            end
            default: begin
               wmask_o = 4'b1111;
               wdata_o = storeData_i;
            end
         endcase
      end
   end

   // Pick the addressed byte/halfword out of the memory word and extend it
   always_comb begin
      byteSel = loadWord_i[{offset_i, 3'b000} +: 8];
      halfSel = offset_i[1] ? loadWord_i[31:16] : loadWord_i[15:0];
      case (effFunct3)
         lb:      rdata_o = {{24{byteSel[7]}}, byteSel};
         lbu:     rdata_o = {24'h000000, byteSel};
         lh:      rdata_o = {{16{halfSel[15]}}, halfSel};
         lhu:     rdata_o = {16'h0000, halfSel};
         default: rdata_o = loadWord_i;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Multicycle load/store stage: accepts one request, checks it, runs a
// word-aligned memory handshake and returns extended load data.
module load_store_unit
   import rv32i_types::*;
#(
   parameter bit NONE_FUNCT3_CHECK = 1'b1
)
(
   input  logic           clk,
   input  logic           rst_n,
   input  logic           req_valid,
   output logic           req_ready,
   input  logic           req_is_store,
   input  logic [2:0]     req_funct3,
   input  rv32i_word      req_addr,
   input  rv32i_word      req_wdata,
   input  rv32i_reg       req_rd,
   output logic           resp_valid,
   output rv32i_word      resp_rdata,
   output rv32i_reg       resp_rd,
   output logic           resp_fault,
   output rv32i_word      mem_address,
   output logic           mem_read,
   output logic           mem_write,
   output rv32i_mem_wmask mem_wmask,
   output rv32i_word      mem_wdata,
   input  rv32i_word      mem_rdata,
   input  logic           mem_resp
);

   lsu_state_t state_q, state_d;
   logic       isStore_q, isStore_d;
   logic [2:0] funct3_q, funct3_d;
   rv32i_word  addr_q, addr_d;
   rv32i_word  wdata_q, wdata_d;
   rv32i_word  rdata_q, rdata_d;
   rv32i_reg   rd_q, rd_d;
   logic       fault_q, fault_d;

   logic           inIdle;
   logic           alignIsStore;
   logic [2:0]     alignFunct3;
   logic [1:0]     alignOffset;
   rv32i_word      alignStoreData;
   rv32i_mem_wmask alignWmask;
   rv32i_word      alignWdata;
   rv32i_word      alignRdata;
   logic           alignFault;

   // While idle the lane logic inspects the incoming request so a fault is
   // known at the accept edge; afterwards it works on the captured request.
   assign inIdle         = (state_q == IDLE);
   assign alignIsStore   = inIdle ? req_is_store    : isStore_q;
   assign alignFunct3    = inIdle ? req_funct3      : funct3_q;
   assign alignOffset    = inIdle ? req_addr[1:0]   : addr_q[1:0];
   assign alignStoreData = inIdle ? req_wdata       : wdata_q;

   lsu_align #(
      .NONE_FUNCT3_CHECK (NONE_FUNCT3_CHECK)
   ) uAlign (
      .isStore_i   (alignIsStore),
      .funct3_i    (alignFunct3),
      .offset_i    (alignOffset),
      .storeData_i (alignStoreData),
      .loadWord_i  (mem_rdata),
      .wmask_o     (alignWmask),
      .wdata_o     (alignWdata),
      .rdata_o     (alignRdata),
      .fault_o     (alignFault)
   );

   // State and captured request registers; reset aborts any transaction
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         isStore_q <= 1'b0;
         funct3_q  <= 3'b000;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         rd_q      <= '0;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         isStore_q <= isStore_d;
         funct3_q  <= funct3_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         rd_q      <= rd_d;
         fault_q   <= fault_d;
      end
   end

   // Next-state, capture and output decode for IDLE -> MEM -> RESP
   always_comb begin
      state_d     = state_q;
      isStore_d   = isStore_q;
      funct3_d    = funct3_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      rd_d        = rd_q;
      fault_d     = fault_q;
      req_ready   = 1'b0;
      resp_valid  = 1'b0;
      resp_rdata  = '0;
      resp_rd     = '0;
      resp_fault  = 1'b0;
      mem_address = '0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      mem_wmask   = '0;
      mem_wdata   = '0;

      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               isStore_d = req_is_store;
               funct3_d  = req_funct3;
               addr_d    = req_addr;
               wdata_d   = req_wdata;
               rd_d      = req_rd;
               rdata_d   = '0;
               fault_d   = alignFault;
               state_d   = alignFault ? RESP : MEM;
            end
         end
         MEM: begin
            mem_address = {addr_q[31:2], 2'b00};
            mem_read    = !isStore_q;
            mem_write   = isStore_q;
            if (isStore_q) begin
               mem_wmask = alignWmask;
               mem_wdata = alignWdata;
            end
            if (mem_resp) begin
               rdata_d = isStore_q ? '0 : alignRdata;
               state_d = RESP;
            end
         end
         RESP: begin
            resp_valid = 1'b1;
            resp_rdata = rdata_q;
            resp_rd    = isStore_q ? '0 : rd_q;
            resp_fault = fault_q;
            state_d    = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed vector table, randomized requests
// against a byte-level reference model, and reset / stray-response sequences.
module tb_load_store_unit;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_is_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [4:0]  req_rd;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic [4:0]  resp_rd;
   logic        resp_fault;
   logic [31:0] mem_address;
   logic        mem_read;
   logic        mem_write;
   logic [3:0]  mem_wmask;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_resp;

   int testsRun;
   int testsFailed;

   typedef struct {
      logic        isStore;
      logic [2:0]  funct3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [4:0]  rd;
      logic [31:0] rdata;
      int          delay;
      logic        expFault;
      logic [3:0]  expWmask;
      logic [31:0] expWdata;
      logic [31:0] expRdata;
   } vector_t;

   vector_t vectors[10];

   load_store_unit dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_is_store (req_is_store),
      .req_funct3   (req_funct3),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .req_rd       (req_rd),
      .resp_valid   (resp_valid),
      .resp_rdata   (resp_rdata),
      .resp_rd      (resp_rd),
      .resp_fault   (resp_fault),
      .mem_address  (mem_address),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .mem_wmask    (mem_wmask),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .mem_resp     (mem_resp)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case a sequence ever stalls
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference model: works from access size in bytes and byte offsets
   function automatic void refModel(input logic isS, input logic [2:0] f3,
                                    input logic [31:0] addr, input logic [31:0] wdata,
                                    input logic [31:0] rdata, output logic fault,
                                    output logic [3:0] wm, output logic [31:0] wd,
                                    output logic [31:0] rd);
      int size;
      int off;
      logic illegal;
      logic [31:0] mask;
      off = int'(addr[1:0]);
      illegal = isS ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
      wm = 4'b0000;
      wd = 32'h0;
      rd = 32'h0;
      fault = 1'b1;
      if (illegal) return;
      size = 1 << int'(f3[1:0]);
      if ((off % size) != 0) return;
      fault = 1'b0;
      if (isS) begin
         wm = 4'(((1 << size) - 1) << off);
         for (int i = 0; i < 4; i++) begin
            wd[8*i +: 8] = wdata[8*(i % size) +: 8];
         end
      end else begin
         rd = rdata >> (8 * off);
         if (size < 4) begin
            mask = (32'h1 << (8 * size)) - 32'h1;
            rd = rd & mask;
            if (!f3[2] && rd[8*size-1]) rd = rd | ~mask;
         end
      end
   endfunction

   // One full transaction: issue, serve memory after `delay` strobe cycles, check response
   task automatic applyStimulus(input logic isS, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [4:0] rd,
                                input logic [31:0] rdata, input int delay,
                                input logic expFault, input logic [3:0] expWmask,
                                input logic [31:0] expWdata, input logic [31:0] expRdata);
      @(negedge clk);
      checkOutput("ready_idle", 32'(req_ready), 32'd1);
      req_valid    = 1'b1;
      req_is_store = isS;
      req_funct3   = f3;
      req_addr     = addr;
      req_wdata    = wdata;
      req_rd       = rd;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      req_addr  = $urandom;
      req_wdata = $urandom;
      req_rd    = 5'($urandom);
      if (expFault) begin
         checkOutput("fault_valid", 32'(resp_valid), 32'd1);
         checkOutput("fault_flag", 32'(resp_fault), 32'd1);
         checkOutput("fault_no_read", 32'(mem_read), 32'd0);
         checkOutput("fault_no_write", 32'(mem_write), 32'd0);
         checkOutput("fault_rdata", resp_rdata, 32'h0);
      end else begin
         for (int i = 1; i <= delay; i++) begin
            if (i > 1) @(negedge clk);
            checkOutput("mem_read", 32'(mem_read), 32'(!isS));
            checkOutput("mem_write", 32'(mem_write), 32'(isS));
            checkOutput("mem_address", mem_address, {addr[31:2], 2'b00});
            checkOutput("mem_wmask", 32'(mem_wmask), 32'(expWmask));
            if (isS) checkOutput("mem_wdata", mem_wdata, expWdata);
            checkOutput("busy_ready", 32'(req_ready), 32'd0);
            checkOutput("busy_valid", 32'(resp_valid), 32'd0);
            if (i == delay) begin
               mem_resp  = 1'b1;
               mem_rdata = rdata;
            end else begin
               mem_rdata = $urandom;
            end
         end
         @(negedge clk);
         mem_resp  = 1'b0;
         mem_rdata = $urandom;
         checkOutput("resp_valid", 32'(resp_valid), 32'd1);
         checkOutput("resp_fault", 32'(resp_fault), 32'd0);
         checkOutput("resp_rdata", resp_rdata, expRdata);
         checkOutput("resp_rd", 32'(resp_rd), isS ? 32'd0 : 32'(rd));
         checkOutput("resp_strobes", 32'({mem_read, mem_write}), 32'd0);
      end
      @(negedge clk);
      checkOutput("post_valid", 32'(resp_valid), 32'd0);
      checkOutput("post_ready", 32'(req_ready), 32'd1);
   endtask

   logic        mFault;
   logic [3:0]  mWmask;
   logic [31:0] mWdata;
   logic [31:0] mRdata;

   initial begin
      testsRun     = 0;
      testsFailed  = 0;
      rst_n        = 1'b1;
      req_valid    = 1'b0;
      req_is_store = 1'b0;
      req_funct3   = 3'b000;
      req_addr     = 32'h0;
      req_wdata    = 32'h0;
      req_rd       = 5'd0;
      mem_rdata    = 32'h0;
      mem_resp     = 1'b0;

      //                  st    f3      addr          wdata         rd     rdata         dly flt wmask    wdata         rdata
      vectors[0] = '{1'b0, 3'b000, 32'h0000_1003, 32'h0,        5'd5,  32'h80FF_1234, 2, 1'b0, 4'b0000, 32'h0,        32'hFFFF_FF80};
      vectors[1] = '{1'b0, 3'b101, 32'h0000_2002, 32'h0,        5'd7,  32'h8001_0000, 1, 1'b0, 4'b0000, 32'h0,        32'h0000_8001};
      vectors[2] = '{1'b0, 3'b001, 32'h0000_2002, 32'h0,        5'd8,  32'h8001_0000, 1, 1'b0, 4'b0000, 32'h0,        32'hFFFF_8001};
      vectors[3] = '{1'b1, 3'b000, 32'h0000_3001, 32'h1234_56AB, 5'd9,  32'h5555_5555, 3, 1'b0, 4'b0010, 32'hABAB_ABAB, 32'h0};
      vectors[4] = '{1'b1, 3'b001, 32'h0000_4002, 32'h0000_BEEF, 5'd10, 32'h0,        1, 1'b0, 4'b1100, 32'hBEEF_BEEF, 32'h0};
      vectors[5] = '{1'b0, 3'b010, 32'h0000_5001, 32'h0,        5'd11, 32'h0,        1, 1'b1, 4'b0000, 32'h0,        32'h0};
      vectors[6] = '{1'b0, 3'b011, 32'h0000_6000, 32'h0,        5'd12, 32'h0,        1, 1'b1, 4'b0000, 32'h0,        32'h0};
      vectors[7] = '{1'b1, 3'b010, 32'h0000_7000, 32'hCAFE_F00D, 5'd13, 32'h0,        2, 1'b0, 4'b1111, 32'hCAFE_F00D, 32'h0};
      vectors[8] = '{1'b0, 3'b010, 32'h0000_8004, 32'h0,        5'd31, 32'h1234_5678, 1, 1'b0, 4'b0000, 32'h0,        32'h1234_5678};
      vectors[9] = '{1'b0, 3'b100, 32'h0000_9002, 32'h0,        5'd1,  32'h00AB_0000, 4, 1'b0, 4'b0000, 32'h0,        32'h0000_00AB};

      // Reset values
      #2 rst_n = 1'b0;
      #3;
      checkOutput("rst_ready", 32'(req_ready), 32'd1);
      checkOutput("rst_valid", 32'(resp_valid), 32'd0);
      checkOutput("rst_strobes", 32'({mem_read, mem_write}), 32'd0);
      checkOutput("rst_address", mem_address, 32'h0);
      checkOutput("rst_wmask", 32'(mem_wmask), 32'd0);
      checkOutput("rst_wdata", mem_wdata, 32'h0);
      checkOutput("rst_rdata", resp_rdata, 32'h0);
      checkOutput("rst_rd", 32'(resp_rd), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors
      for (int v = 0; v < 10; v++) begin
         applyStimulus(vectors[v].isStore, vectors[v].funct3, vectors[v].addr, vectors[v].wdata,
                       vectors[v].rd, vectors[v].rdata, vectors[v].delay, vectors[v].expFault,
                       vectors[v].expWmask, vectors[v].expWdata, vectors[v].expRdata);
      end

      // Randomized requests checked against the reference model
      for (int n = 0; n < 60; n++) begin
         logic        isS;
         logic [2:0]  f3;
         logic [31:0] addr;
         logic [31:0] wdata;
         logic [31:0] rdata;
         logic [4:0]  rd;
         int          dly;
         isS = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 9) < 8) begin
            f3 = isS ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 4));
            if (!isS && f3 == 3'd3) f3 = 3'd5;
         end else begin
            f3 = 3'($urandom);
         end
         addr  = $urandom;
         wdata = $urandom;
         rdata = $urandom;
         rd    = 5'($urandom);
         dly   = $urandom_range(1, 4);
         refModel(isS, f3, addr, wdata, rdata, mFault, mWmask, mWdata, mRdata);
         applyStimulus(isS, f3, addr, wdata, rd, rdata, dly, mFault, mWmask, mWdata, mRdata);
      end

      // Reset in the middle of a memory access, then a stray mem_resp while idle
      @(negedge clk);
      req_valid    = 1'b1;
      req_is_store = 1'b0;
      req_funct3   = 3'b010;
      req_addr     = 32'h0000_A000;
      req_rd       = 5'd3;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      checkOutput("abort_read_before", 32'(mem_read), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("abort_read_drop", 32'(mem_read), 32'd0);
      checkOutput("abort_address", mem_address, 32'h0);
      checkOutput("abort_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      rst_n     = 1'b1;
      mem_resp  = 1'b1;
      mem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      mem_resp = 1'b0;
      checkOutput("stray_valid", 32'(resp_valid), 32'd0);
      checkOutput("stray_ready", 32'(req_ready), 32'd1);
      checkOutput("stray_read", 32'(mem_read), 32'd0);
      @(negedge clk);
      checkOutput("stray_valid_late", 32'(resp_valid), 32'd0);

      // Unit still works after the abort
      applyStimulus(1'b0, 3'b001, 32'h0000_B002, 32'h0, 5'd20, 32'h7FFF_0000, 2,
                    1'b0, 4'b0000, 32'h0, 32'h0000_7FFF);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Multicycle load/store stage between execute and the data-memory port. Consumes the RV32I load/store funct3 encodings and the 4-bit write-mask type from the shared rv32i_types package.
- Accepts one memory request at a time and checks alignment.
- Drives a word-aligned memory handshake, generates byte masks and lane-replicated store data, and returns sign- or zero-extended load data with the destination register.

Parameters:
- NONE_FUNCT3_CHECK, 1, when 1 an illegal funct3 raises a fault; when 0 it is treated as lw/sw.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit idle, can accept a request
- req_is_store  in  1  1=store, 0=load
- req_funct3  in  3  load_funct3_t / store_funct3_t encoding
- req_addr  in  32  byte address (rv32i_word)
- req_wdata  in  32  store data, right-aligned
- req_rd  in  5  load destination (rv32i_reg)
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and faults
- resp_rd  out  5  captured rd; 0 for stores
- resp_fault  out  1  misaligned or illegal access, qualified by resp_valid
- mem_address  out  32  {addr[31:2],2'b00}
- mem_read  out  1  load strobe
- mem_write  out  1  store strobe
- mem_wmask  out  4  byte enables (rv32i_mem_wmask)
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  memory read word
- mem_resp  in  1  memory completion, single cycle

Behaviour:
- States: IDLE, MEM, RESP. Reset (async, rst_n=0) puts the unit in IDLE and clears all captured registers.
- Output reset values: req_ready=1; resp_valid=0; mem_read=0; mem_write=0; all data, address and mask outputs 0.
- IDLE: req_ready=1. A request is accepted when req_valid=1 at a rising edge, and all request fields are captured.
  - Faulting request: goes to RESP.
  - Any other request: goes to MEM.
- Fault conditions:
  - lh, lhu or sh with addr[0]=1.
  - lw or sw with addr[1:0]!=0.
  - When NONE_FUNCT3_CHECK=1, load funct3 of 011, 110 or 111, or store funct3 above 010.
  - A faulting request never asserts mem_read or mem_write.
- MEM state:
  - mem_read or mem_write is held high, with address, mask and wdata stable, until mem_resp=1.
  - On the mem_resp edge, load data is extracted into resp_rdata and the unit goes to RESP.
  - mem_resp arriving outside MEM is ignored.
- RESP state: resp_valid=1 for exactly one cycle with no backpressure, then IDLE. req_ready=0 in both MEM and RESP.
- Latency:
  - Accept at edge T. mem strobes are high during cycle T+1.
  - mem_resp sampled at edge T+k gives resp_valid during cycle T+k+1.
  - A fault gives resp_valid during cycle T+1.
  - Minimum throughput is one request per 3 cycles.
- Write mask, with off=addr[1:0]:
  - sb: 4'b0001<<off
  - sh: 4'b0011<<off
  - sw: 4'b1111
  - mem_wmask=0 for loads.
- Store data:
  - sb: {4{wdata[7:0]}}
  - sh: {2{wdata[15:0]}}
  - sw: wdata
- Load extraction:
  - lb and lbu select byte off; lh and lhu select halfword off[1].
  - lb and lh sign-extend; lbu and lhu zero-extend; lw passes the word.
- Reset mid-MEM: strobes drop immediately on rst_n low. No response is ever produced for the aborted request.
- Stores: resp_valid pulses with resp_rd=0 and resp_rdata=0.

Decomposition:
- Add to rv32i_types:
  - lsu_state_t enum {IDLE, MEM, RESP}
  - helper constants for the halfword and word alignment masks
- Sub-module lsu_align, purely combinational:
  - inputs: funct3, offset, raw words
  - outputs: wmask, replicated wdata, extended rdata, fault flag
- The FSM and registers stay in load_store_unit.

Test Plan:
- lb at addr 0x0000_1003, mem_rdata 0x80FF_1234, mem_resp 2 cycles after strobe:
  - mem_address 0x1000, mem_read=1 for 2 cycles
  - resp_rdata 0xFFFF_FF80 with resp_rd echoed
  - resp_valid one cycle after mem_resp
- lhu at 0x2002, mem_rdata 0x8001_0000 -> resp_rdata 0x0000_8001. Same request as lh -> 0xFFFF_8001.
- sb at 0x3001, wdata 0x1234_56AB -> mem_wmask 4'b0010, mem_wdata 0xABAB_ABAB, mem_write held until mem_resp, resp_rdata 0.
- sh at 0x4002 with wdata 0x0000_BEEF -> wmask 4'b1100, wdata 0xBEEF_BEEF.
- Fault case, lw at 0x5001:
  - no mem_read
  - resp_valid with resp_fault=1 in cycle T+1
  - req_ready=1 again in cycle T+2
- Fault case, load funct3 3'b011 -> fault.
- Reset mid-operation: assert rst_n=0 during MEM -> mem_read drops asynchronously, no resp_valid, req_ready=1 after release. Also check that mem_resp pulsed in IDLE is ignored.
